// File: rtl/risc_fetch_pkg.sv
// Shared widths, reset PC and FSM state type for the instruction fetch stage.
// Imported by fetch_unit and fetch_perf_counters.
package risc_fetch_pkg;

   localparam int PC_W   = 16;
   localparam int INST_W = 16;

   localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 16'h0000;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_t;

   // Word-address increment; wraps silently at the top of the 16-bit space.
   function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] p);
      return p + PC_W'(1);
   endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Saturating event counters for the fetch stage (fetch captures, stall cycles, flushes).
// Only instantiated when FETCH_PERF_EN is defined.
module fetch_perf_counters
   import risc_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_evt,
   input  logic        stall_evt,
   input  logic        flush_evt,
   output logic [31:0] perf_fetch_count,
   output logic [31:0] perf_stall_count,
   output logic [15:0] perf_flush_count
);

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetch_count <= '0;
         perf_stall_count <= '0;
         perf_flush_count <= '0;
      end else begin
         // Each counter sticks at all-ones instead of wrapping.
         if (fetch_evt && (perf_fetch_count != '1))
            perf_fetch_count <= perf_fetch_count + 32'd1;
         if (stall_evt && (perf_stall_count != '1))
            perf_stall_count <= perf_stall_count + 32'd1;
         if (flush_evt && (perf_flush_count != '1))
            perf_flush_count <= perf_flush_count + 16'd1;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, registers the memory word into IF/ID,
// handles stall, redirect/flush and sticky halt. FETCH_PERF_EN adds perf counters.
//
// state  | meaning
// -------+-----------------------------------------------------------
// RUN    | fetching one word per cycle whenever decode can take it
// HALTED | no capture, pc frozen; left only by a redirect
module fetch_unit
   import risc_fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int              INST_W   = risc_fetch_pkg::INST_W
) (
   input  logic              clk,
   input  logic              reset,
   output logic [PC_W-1:0]   pc,
   input  logic [INST_W-1:0] instruction,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   input  logic              halt_req,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [INST_W-1:0] id_instr,
   output logic [PC_W-1:0]   id_pc,
   output logic              halted
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]       perf_fetch_count,
   output logic [31:0]       perf_stall_count,
   output logic [15:0]       perf_flush_count
`endif
);

   fetch_state_t state;
   logic         advance;
   logic         stall;

   assign advance = !id_valid || id_ready;
   assign stall   = !advance;

   // Priority per edge: reset > redirect > stall > halt > fetch.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc       <= RESET_PC;
         id_valid <= 1'b0;
         id_instr <= '0;
         id_pc    <= '0;
         state    <= RUN;
         halted   <= 1'b0;
      end else if (redirect_valid) begin
         pc       <= redirect_pc;
         id_valid <= 1'b0;
         state    <= RUN;
         halted   <= 1'b0;
      end else if (stall) begin
         // Held word stays put, but a halt request must not be lost.
         if ((state == RUN) && halt_req) begin
            state  <= HALTED;
            halted <= 1'b1;
         end
      end else if ((state == HALTED) || halt_req) begin
         id_valid <= 1'b0;
         state    <= HALTED;
         halted   <= 1'b1;
      end else begin
         id_instr <= instruction;
         id_pc    <= pc;
         id_valid <= 1'b1;
         pc       <= pc_inc(pc);
      end
   end

`ifdef FETCH_PERF_EN
   logic fetch_evt;
   logic stall_evt;
   logic flush_evt;

   assign fetch_evt = !reset && !redirect_valid && advance && (state == RUN) && !halt_req;
   assign stall_evt = !reset && !redirect_valid && stall;
   assign flush_evt = !reset && redirect_valid && id_valid;

   fetch_perf_counters u_perf (
      .clk              (clk),
      .reset            (reset),
      .fetch_evt        (fetch_evt),
      .stall_evt        (stall_evt),
      .flush_evt        (flush_evt),
      .perf_fetch_count (perf_fetch_count),
      .perf_stall_count (perf_stall_count),
      .perf_flush_count (perf_flush_count)
   );
`endif

endmodule
